// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: operand/result valid-ready handshake bundle for the serial ALU
interface serial_alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial add/subtract, one full-adder slice reused LSB first over WIDTH cycles
module serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  serial_alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CNT_W-1:0] count;
  logic carry, co, ov, last;
  logic h1, g1, s, c_n;
  // full adder built from two half adders plus carry OR
  assign h1 = sh_a[0] ^ sh_b[0];
  assign g1 = sh_a[0] & sh_b[0];
  assign s = h1 ^ carry;
  assign c_n = g1 | (h1 & carry);
  assign last = count == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      res <= '0;
      count <= '0;
      carry <= 1'b0;
      co <= 1'b0;
      ov <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      sh_a <= bus.op_a;
      sh_b <= bus.op_sub ? ~bus.op_b : bus.op_b;
      carry <= bus.op_sub;
      count <= '0;
      res <= '0;
    end else if (state == RUN) begin
      res <= {s, res[WIDTH-1:1]};
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      carry <= c_n;
      if (!last) count <= count + 1'b1;
      if (last) begin
        ov <= carry ^ c_n;
        co <= c_n;
      end
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.result = res;
  assign bus.carry_out = co;
  assign bus.overflow = ov;
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: scoreboard bench for the serial ALU against an arithmetic reference model
module tb_serial_alu_seq;
  localparam int W = 8;
  typedef struct packed {logic [W-1:0] res; logic co; logic ov;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  serial_alu_seq_if #(.WIDTH(W)) bus();
  serial_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc = 0;
  logic in_op = 1'b0;
  logic b2b = 1'b0;
  logic prev_b2b = 1'b0;
  int prev_acc = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int u, sv;
    exp_t e;
    u = sub ? ua + ((1 << W) - 1 - ub) + 1 : ua + ub;
    sv = sub ? sa - sb : sa + sb;
    e.res = u[W-1:0];
    e.co = u[W];
    e.ov = (sv < -(1 << (W - 1))) || (sv > (1 << (W - 1)) - 1);
    return e;
  endfunction
  // monitor: protocol timing from a transaction-level view, plus scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_op = 1'b0;
      prev_b2b = 1'b0;
    end else begin
      cyc++;
      chk("in_ready", bus.in_ready, !in_op);
      chk("busy", bus.busy, in_op);
      chk("out_valid", bus.out_valid, in_op && (cyc - acc >= W));
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_depth", sbq.size(), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("result", bus.result, e.res);
          chk("carry_out", bus.carry_out, e.co);
          chk("overflow", bus.overflow, e.ov);
        end
        in_op = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (b2b && prev_b2b) chk("issue_interval", cyc + 1 - prev_acc, W + 2);
        acc = cyc + 1;
        prev_acc = acc;
        prev_b2b = b2b;
        in_op = 1'b1;
      end
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic ok = 1'b0;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_sub = sub;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    chk("accept_timeout", ok, 1);
    if (ok) sbq.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    logic ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = bus.out_valid;
    end
    chk("done_timeout", ok, 1);
  endtask
  task automatic drain(input int hold);
    wait_valid();
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [W+1:0] held;
    logic [W-1:0] da [5] = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [W-1:0] db [5] = '{8'h0F, 8'h01, 8'h01, 8'h07, 8'h01};
    logic ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_sub = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry_out, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(da[i], db[i], ds[i]);
      bus.in_valid = 1'b0;
      drain(0);
    end
    // backpressure: DONE held while new operands are offered
    issue(8'h5A, 8'h33, 1'b0);
    bus.in_valid = 1'b0;
    wait_valid();
    held = {bus.result, bus.carry_out, bus.overflow};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i % 2) == 0;
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.op_sub = 1'($urandom);
      @(negedge clk);
      chk("hold_outputs", {bus.result, bus.carry_out, bus.overflow}, held);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(8'hA7, 8'h6D, 1'b1);
    bus.in_valid = 1'b0;
    drain(1);
    // abort mid-run at count 3
    issue(8'h44, 8'h55, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", bus.result, 0);
    chk("abort_carry", bus.carry_out, 0);
    chk("abort_overflow", bus.overflow, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue(8'h10, 8'h20, 1'b0);
    bus.in_valid = 1'b0;
    drain(0);
    // back-to-back with in_valid and out_ready held high
    b2b = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(W'($urandom), W'($urandom), 1'($urandom));
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    b2b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      bus.in_valid = 1'b0;
      drain(int'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
